// File: rtl/alu_mul_sequencer_pkg.sv
// Shared definitions for the shift-add multiplier: state encoding, ALU opcodes, data width.
package alu_mul_sequencer_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY,
    DONE = ST_DONE
  } state_e;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_mul_sequencer_if.sv
// Operand request / product response handshake bundle between a requester and the multiplier.
interface alu_mul_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_WIDTH-1:0]     op_a;
  logic [DATA_WIDTH-1:0]     op_b;
  logic                      out_valid;
  logic                      out_ready;
  logic [2*DATA_WIDTH-1:0]   product;

  modport master (
    output in_valid, op_a, op_b, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, op_a, op_b, out_ready,
    output in_ready, out_valid, product
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Unsigned DATA_WIDTH x DATA_WIDTH shift-add multiplier that drives an external combinational ALU.
// Optional feature macro: MUL_EARLY_TERM_EN (stop once the remaining multiplier bits are zero).
module alu_mul_sequencer
  import alu_mul_sequencer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_mul_sequencer_if.slave    mul,
  output logic [DATA_WIDTH-1:0] alu_A,
  output logic [DATA_WIDTH-1:0] alu_B,
  output logic [2:0]            alu_op,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_carry
);

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   mcand_q, mplr_q, acc_q, lo_q;
  logic [DATA_WIDTH-1:0]   mplr_d, acc_d, lo_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [2*DATA_WIDTH-1:0] product_q, product_d;
  logic                    in_ready_q, out_valid_q;
  logic                    last_step;
  logic [DATA_WIDTH:0]     sum;

  assign alu_A  = acc_q;
  assign alu_B  = mcand_q;
  assign alu_op = (state_q == BUSY) ? ALU_ADD : ALU_AND;

  assign mul.in_ready  = in_ready_q;
  assign mul.out_valid = out_valid_q;
  assign mul.product   = product_q;

  // One shift-add step: the 33-bit ALU sum (or the unchanged acc) shifts right into {acc,lo}.
  always_comb begin
    sum    = {alu_carry, alu_result};
    acc_d  = {1'b0, acc_q[DATA_WIDTH-1:1]};
    lo_d   = {acc_q[0], lo_q[DATA_WIDTH-1:1]};
    if (mplr_q[0]) begin
      acc_d = sum[DATA_WIDTH:1];
      lo_d  = {sum[0], lo_q[DATA_WIDTH-1:1]};
    end
    mplr_d = mplr_q >> 1;
    cnt_d  = cnt_q + 1'b1;
  end

`ifdef MUL_EARLY_TERM_EN
  logic [CNT_W:0] shamt;

  // Finishing early leaves the partial product only cnt bits into lo; realign it to bit 0.
  always_comb begin
    last_step = (mplr_q == '0) || (mplr_d == '0);
    if (mplr_q == '0) begin
      shamt     = DATA_WIDTH[CNT_W:0] - {1'b0, cnt_q};
      product_d = {acc_q, lo_q} >> shamt;
    end else begin
      shamt     = DATA_WIDTH[CNT_W:0] - {1'b0, cnt_d};
      product_d = {acc_d, lo_d} >> shamt;
    end
  end
`else
  always_comb begin
    last_step = (cnt_q == CNT_W'(DATA_WIDTH - 1));
    product_d = {acc_d, lo_d};
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      product_q   <= '0;
      mcand_q     <= '0;
      mplr_q      <= '0;
      acc_q       <= '0;
      lo_q        <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mul.in_valid) begin
            state_q    <= BUSY;
            in_ready_q <= 1'b0;
            mcand_q    <= mul.op_a;
            mplr_q     <= mul.op_b;
            acc_q      <= '0;
            lo_q       <= '0;
            cnt_q      <= '0;
          end
        end
        BUSY: begin
          acc_q  <= acc_d;
          lo_q   <= lo_d;
          mplr_q <= mplr_d;
          cnt_q  <= cnt_d;
          if (last_step) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            product_q   <= product_d;
          end
        end
        DONE: begin
          if (mul.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer with a behavioural ALU and a product scoreboard.
module tb_alu_mul_sequencer;
  import alu_mul_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_mul_sequencer_if #(.DATA_WIDTH(32)) mif ();

  logic [31:0] alu_A, alu_B, alu_result;
  logic [2:0]  alu_op;
  logic        alu_carry;
  logic [32:0] alu_wide;

  always_comb begin
    alu_wide = '0;
    case (alu_op)
      ALU_AND: alu_wide = {1'b0, alu_A & alu_B};
      ALU_OR:  alu_wide = {1'b0, alu_A | alu_B};
      ALU_ADD: alu_wide = {1'b0, alu_A} + {1'b0, alu_B};
      ALU_SUB: alu_wide = {1'b0, alu_A} - {1'b0, alu_B};
      ALU_SLT: alu_wide = {32'b0, $signed(alu_A) < $signed(alu_B)};
      default: alu_wide = '0;
    endcase
  end
  assign alu_result = alu_wide[31:0];
  assign alu_carry  = alu_wide[32];

  alu_mul_sequencer #(.DATA_WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mul        (mif),
    .alu_A      (alu_A),
    .alu_B      (alu_B),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_carry  (alu_carry)
  );

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_latency(input logic [31:0] b);
`ifdef MUL_EARLY_TERM_EN
    for (int i = 31; i >= 0; i--)
      if (b[i]) return i + 1;
    return 1;
`else
    return 32;
`endif
  endfunction

  // Issue one multiply, check latency and product, optionally stall the consumer for hold cycles.
  task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int hold);
    int cyc;
    logic [63:0] exp;
    check("accept_in_ready", mif.in_ready, 1);
    mif.op_a      = a;
    mif.op_b      = b;
    mif.in_valid  = 1'b1;
    mif.out_ready = (hold == 0);
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    exp_q.push_back({32'b0, a} * {32'b0, b});
    check("busy_in_ready", mif.in_ready, 0);
    check("busy_alu_op", alu_op, 3'b010);
    cyc = 0;
    while (!mif.out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, exp_latency(b));
    exp = exp_q.pop_front();
    check("product", mif.product, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_out_valid", mif.out_valid, 1);
      check("hold_product", mif.product, exp);
      check("hold_in_ready", mif.in_ready, 0);
    end
    // Offer a new request in the same cycle the product drains; it must not be taken.
    mif.out_ready = 1'b1;
    mif.in_valid  = (hold > 0);
    @(posedge clk); #1;
    mif.out_ready = 1'b0;
    mif.in_valid  = 1'b0;
    check("drain_out_valid", mif.out_valid, 0);
    check("idle_in_ready", mif.in_ready, 1);
    check("idle_alu_op", alu_op, 3'b000);
  endtask

  initial begin
    int seen;
    mif.in_valid  = 1'b0;
    mif.out_ready = 1'b0;
    mif.op_a      = '0;
    mif.op_b      = '0;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", mif.in_ready, 1);
    check("rst_out_valid", mif.out_valid, 0);
    check("rst_product", mif.product, 64'h0);
    check("rst_alu_op", alu_op, 3'b000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_mul(32'd3, 32'd5, 0);
    run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    run_mul(32'h1234_5678, 32'd0, 10);

    // Reset during BUSY discards the in-flight product.
    mif.op_a     = 32'd7;
    mif.op_b     = 32'd9;
    mif.in_valid = 1'b1;
    @(posedge clk); #1;
    mif.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_in_ready", mif.in_ready, 1);
    check("abort_out_valid", mif.out_valid, 0);
    check("abort_alu_op", alu_op, 3'b000);
    seen = 0;
    mif.out_ready = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (mif.out_valid) seen = 1;
    end
    mif.out_ready = 1'b0;
    check("abort_never_valid", seen, 0);
    run_mul(32'd7, 32'd9, 0);

    run_mul(32'd7, 32'd2, 0);
    run_mul(32'd0, 32'd5, 0);
    run_mul(32'h8000_0001, 32'h8000_0003, 1);
    for (int k = 0; k < 3; k++)
      run_mul($urandom, $urandom, k);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
